// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the cpu_ctrl sequencer: widths, opcode and state encodings,
// instruction field layout and opcode-class helpers used by the RTL and the bench.
package cpu_ctrl_pkg;

    localparam int IW = 16;
    localparam int DW = 8;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_AND   = 4'h0;
    localparam logic [3:0] OP_OR    = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_CMP   = 4'h4;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_SUBI  = 4'h6;
    localparam logic [3:0] OP_CMPI  = 4'h7;
    localparam logic [3:0] OP_LTI   = 4'h8;
    localparam logic [3:0] OP_LI    = 4'h9;
    localparam logic [3:0] OP_LOAD  = 4'hA;
    localparam logic [3:0] OP_STORE = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [3:0] OP_JMPR  = 4'hD;
    localparam logic [3:0] OP_JNZ   = 4'hE;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

    typedef struct packed {
        logic [OP_MSB-OP_LSB:0]   op;
        logic [RD_MSB-RD_LSB:0]   rd;
        logic [RS_MSB-RS_LSB:0]   rs;
        logic [IMM_MSB-IMM_LSB:0] imm;
    } instr_t;

    function automatic logic is_legal(input logic [3:0] op);
        return op != 4'hF;
    endfunction

    function automatic logic writes_flag(input logic [3:0] op);
        return op <= OP_LTI;
    endfunction

    function automatic logic writes_rd(input logic [3:0] op);
        return (op <= OP_LI) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// Bus bundle between the sequencer and its environment: run/status, ROM, RAM and alu ports.
// master is the sequencer side, slave is the memories/alu side.
interface cpu_ctrl_if;
    import cpu_ctrl_pkg::*;

    logic          run;
    logic          busy;
    logic          illegal;
    logic [DW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_we;
    logic [DW-1:0] dmem_rdata;
    logic [DW-1:0] alu_in0;
    logic [DW-1:0] alu_in1;
    logic [3:0]    alu_op;
    logic [DW-1:0] alu_out;
    logic          alu_zf;

    modport master (
        input  run, imem_rdata, dmem_rdata, alu_out, alu_zf,
        output busy, illegal, imem_addr, dmem_addr, dmem_wdata, dmem_we,
               alu_in0, alu_in1, alu_op
    );

    modport slave (
        output run, imem_rdata, dmem_rdata, alu_out, alu_zf,
        input  busy, illegal, imem_addr, dmem_addr, dmem_wdata, dmem_we,
               alu_in0, alu_in1, alu_op
    );

endinterface

// File: rtl/cpu_ctrl_regfile.sv
// 4x8 register file: two asynchronous read ports, one synchronous write port.
// A read of the register being written returns the pre-write value.
module cpu_regfile
    import cpu_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [1:0]    i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [1:0]    i_raddr_a,
    input  logic [1:0]    i_raddr_b,
    output logic [DW-1:0] o_rdata_a,
    output logic [DW-1:0] o_rdata_b
);

    logic [DW-1:0] r_regs [4];

    // NOTE: a four-entry file is reset like ordinary flops; a large RAM would not be,
    // because a reset on the array prevents it from mapping onto memory macros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_regs[i] <= '0;
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_regs[i_raddr_a];
    assign o_rdata_b = r_regs[i_raddr_b];

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer: owns PC, IR, RES, flag and the register file,
// drives the external alu and talks to a synchronous ROM and RAM.
module cpu_ctrl
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    cpu_ctrl_if.master bus
);

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [DW-1:0] r_pc;
    logic [DW-1:0] w_pc_nxt;
    logic [DW-1:0] r_res;
    instr_t        r_ir;
    logic          r_flag;
    logic          r_illegal;

    logic [DW-1:0] w_a;
    logic [DW-1:0] w_b;
    logic          w_rf_we;
    logic [DW-1:0] w_rf_wdata;
    logic [3:0]    w_dec_op;
    logic          w_is_load;
    logic          w_is_store;
    logic          w_retire;

    assign w_dec_op   = bus.imem_rdata[OP_MSB:OP_LSB];
    assign w_is_load  = (r_ir.op == OP_LOAD);
    assign w_is_store = (r_ir.op == OP_STORE);

    // STORE retires in MEM; every other instruction retires in WB.
    assign w_retire   = (r_state == ST_WB) || ((r_state == ST_MEM) && w_is_store);
    assign w_rf_we    = (r_state == ST_WB) && writes_rd(r_ir.op);
    assign w_rf_wdata = w_is_load           ? bus.dmem_rdata :
                        (r_ir.op == OP_LI)  ? r_ir.imm       : r_res;

    cpu_regfile u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_rf_we),
        .i_waddr   (r_ir.rd),
        .i_wdata   (w_rf_wdata),
        .i_raddr_a (r_ir.rd),
        .i_raddr_b (r_ir.rs),
        .o_rdata_a (w_a),
        .o_rdata_b (w_b)
    );

    // NOTE: every signal gets a default before the case, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (bus.run) w_state_nxt = ST_FETCH;
            ST_FETCH:  w_state_nxt = ST_DECODE;
            ST_DECODE: w_state_nxt = is_legal(w_dec_op) ? ST_EXEC : ST_ERR;
            ST_EXEC:   w_state_nxt = (w_is_load || w_is_store) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (w_is_store) w_state_nxt = bus.run ? ST_FETCH : ST_IDLE;
                else            w_state_nxt = ST_WB;
            end
            ST_WB:     w_state_nxt = bus.run ? ST_FETCH : ST_IDLE;
            ST_ERR:    w_state_nxt = ST_ERR;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_pc_nxt = r_pc + 8'd1;
        case (r_ir.op)
            OP_JMP:  w_pc_nxt = r_ir.imm;
            OP_JMPR: w_pc_nxt = r_res;
            OP_JNZ:  if (r_flag) w_pc_nxt = r_ir.imm;
            default: ;
        endcase
    end

    // NOTE: state is updated with <= so every register samples pre-edge values,
    // independent of the order of statements or blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            r_res     <= '0;
            r_flag    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_DECODE) begin
                r_ir <= bus.imem_rdata;
                if (!is_legal(w_dec_op)) r_illegal <= 1'b1;
            end
            if (r_state == ST_EXEC) begin
                r_res <= bus.alu_out;
                if (writes_flag(r_ir.op)) r_flag <= bus.alu_zf;
            end
            if (w_retire) r_pc <= w_pc_nxt;
        end
    end

    always_comb begin
        bus.imem_addr  = r_pc;
        bus.busy       = (r_state != ST_IDLE) && (r_state != ST_ERR);
        bus.illegal    = r_illegal;
        bus.alu_op     = '0;
        bus.alu_in0    = '0;
        bus.alu_in1    = '0;
        bus.dmem_addr  = '0;
        bus.dmem_wdata = '0;
        bus.dmem_we    = 1'b0;
        if (r_state == ST_EXEC) begin
            bus.alu_op  = r_ir.op;
            bus.alu_in0 = r_ir.imm;
            case (r_ir.op)
                OP_AND, OP_OR, OP_ADD, OP_SUB, OP_CMP: begin
                    bus.alu_in0 = w_b;
                    bus.alu_in1 = w_a;
                end
                OP_ADDI, OP_SUBI, OP_CMPI, OP_LTI: bus.alu_in1 = w_a;
                OP_LOAD, OP_STORE, OP_JMPR:        bus.alu_in1 = w_b;
                default: ;
            endcase
        end
        if (r_state == ST_MEM) begin
            bus.dmem_addr = r_res;
            if (w_is_store) begin
                bus.dmem_we    = 1'b1;
                bus.dmem_wdata = w_a;
            end
        end
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: behavioural ROM, RAM and alu models around the sequencer,
// one task per scenario with hand-computed expectations.
module tb_cpu_ctrl;
    import cpu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    logic [15:0] rom [256];
    logic [7:0]  ram [256];
    logic [7:0]  alu_res;

    int          ncyc;
    int          we_cnt;
    logic [7:0]  we_addr, we_data, fetch_addr, ex_in0, ex_in1;
    logic [3:0]  ex_op;

    cpu_ctrl_if bus();

    cpu_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.imem_rdata <= rom[bus.imem_addr];

    always @(posedge clk) begin
        if (bus.dmem_we) ram[bus.dmem_addr] <= bus.dmem_wdata;
        bus.dmem_rdata <= ram[bus.dmem_addr];
    end

    always_comb begin
        alu_res = 8'h00;
        case (bus.alu_op)
            OP_AND:                               alu_res = bus.alu_in0 & bus.alu_in1;
            OP_OR:                                alu_res = bus.alu_in0 | bus.alu_in1;
            OP_ADD, OP_ADDI, OP_LOAD, OP_STORE,
            OP_JMPR:                              alu_res = bus.alu_in0 + bus.alu_in1;
            OP_SUB, OP_SUBI:                      alu_res = bus.alu_in1 - bus.alu_in0;
            OP_CMP, OP_CMPI:                      alu_res = {7'd0, bus.alu_in0 == bus.alu_in1};
            OP_LTI:                               alu_res = {7'd0, bus.alu_in0 > bus.alu_in1};
            default:                              alu_res = bus.alu_in0;
        endcase
    end

    assign bus.alu_out = alu_res;
    assign bus.alu_zf  = (alu_res != 8'h00);

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic fill_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    endtask

    task automatic do_reset();
        bus.run = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one instruction with run pulsed for a single cycle; counts busy cycles.
    task automatic run_one();
        ncyc   = 0;
        we_cnt = 0;
        @(negedge clk);
        bus.run = 1'b1;
        @(posedge clk); #1;
        bus.run = 1'b0;
        while (bus.busy === 1'b1 && ncyc < 20) begin
            ncyc++;
            if (ncyc == 1) fetch_addr = bus.imem_addr;
            if (ncyc == 3) begin
                ex_op  = bus.alu_op;
                ex_in0 = bus.alu_in0;
                ex_in1 = bus.alu_in1;
            end
            if (bus.dmem_we === 1'b1) begin
                we_cnt++;
                we_addr = bus.dmem_addr;
                we_data = bus.dmem_wdata;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        fill_rom();
        do_reset();
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.illegal !== 1'b0) $display("FAIL reset_illegal: got %b want 0", bus.illegal); else n_pass++;
        n_total++; if (bus.imem_addr !== 8'h00) $display("FAIL reset_pc: got %h want 00", bus.imem_addr); else n_pass++;
        n_total++; if (bus.dmem_we !== 1'b0) $display("FAIL reset_we: got %b want 0", bus.dmem_we); else n_pass++;
        n_total++; if (bus.alu_op !== 4'h0 || bus.alu_in0 !== 8'h00 || bus.alu_in1 !== 8'h00)
            $display("FAIL reset_alu: got op=%h in0=%h in1=%h want 0/00/00", bus.alu_op, bus.alu_in0, bus.alu_in1);
            else n_pass++;
        @(posedge clk); #1;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL idle_hold: got busy %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_sub();
        fill_rom();
        rom[0] = enc(OP_LI, 2'd1, 2'd0, 8'd5);
        rom[1] = enc(OP_LI, 2'd2, 2'd0, 8'd3);
        rom[2] = enc(OP_SUB, 2'd1, 2'd2, 8'd0);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            run_one();
            n_total++; if (ncyc !== 4) $display("FAIL sub_lat%0d: got %0d want 4", k, ncyc); else n_pass++;
        end
        n_total++; if (ex_op !== OP_SUB || ex_in0 !== 8'd3 || ex_in1 !== 8'd5)
            $display("FAIL sub_alu: got op=%h in0=%h in1=%h want 3/03/05", ex_op, ex_in0, ex_in1);
            else n_pass++;
        n_total++; if (dut.u_regfile.r_regs[1] !== 8'd2) $display("FAIL sub_r1: got %h want 02", dut.u_regfile.r_regs[1]); else n_pass++;
        n_total++; if (dut.u_regfile.r_regs[2] !== 8'd3) $display("FAIL sub_r2: got %h want 03", dut.u_regfile.r_regs[2]); else n_pass++;
        n_total++; if (dut.r_flag !== 1'b1) $display("FAIL sub_flag: got %b want 1", dut.r_flag); else n_pass++;
        n_total++; if (bus.imem_addr !== 8'h03) $display("FAIL sub_pc: got %h want 03", bus.imem_addr); else n_pass++;
    endtask

    task automatic test_store_load();
        fill_rom();
        rom[0] = enc(OP_LI, 2'd0, 2'd0, 8'd7);
        rom[1] = enc(OP_STORE, 2'd0, 2'd3, 8'h10);
        rom[2] = enc(OP_LOAD, 2'd2, 2'd3, 8'h10);
        do_reset();
        run_one();
        run_one();
        n_total++; if (ncyc !== 4) $display("FAIL store_lat: got %0d want 4", ncyc); else n_pass++;
        n_total++; if (we_cnt !== 1) $display("FAIL store_we_cnt: got %0d want 1", we_cnt); else n_pass++;
        n_total++; if (we_addr !== 8'h10 || we_data !== 8'h07)
            $display("FAIL store_bus: got addr=%h data=%h want 10/07", we_addr, we_data); else n_pass++;
        n_total++; if (ram[8'h10] !== 8'h07) $display("FAIL store_ram: got %h want 07", ram[8'h10]); else n_pass++;
        run_one();
        n_total++; if (ncyc !== 5) $display("FAIL load_lat: got %0d want 5", ncyc); else n_pass++;
        n_total++; if (we_cnt !== 0) $display("FAIL load_we: got %0d strobes want 0", we_cnt); else n_pass++;
        n_total++; if (dut.u_regfile.r_regs[2] !== 8'h07) $display("FAIL load_r2: got %h want 07", dut.u_regfile.r_regs[2]); else n_pass++;
        n_total++; if (bus.imem_addr !== 8'h03) $display("FAIL load_pc: got %h want 03", bus.imem_addr); else n_pass++;
    endtask

    task automatic test_jnz();
        logic [7:0] subi_imm [2];
        logic [7:0] exp_pc [2];
        logic       exp_flag [2];
        subi_imm = '{8'd1, 8'd0};
        exp_pc   = '{8'h03, 8'h40};
        exp_flag = '{1'b0, 1'b1};
        for (int k = 0; k < 2; k++) begin
            fill_rom();
            rom[0] = enc(OP_LI, 2'd1, 2'd0, 8'd1);
            rom[1] = enc(OP_SUBI, 2'd1, 2'd0, subi_imm[k]);
            rom[2] = enc(OP_JNZ, 2'd0, 2'd0, 8'h40);
            do_reset();
            repeat (3) run_one();
            n_total++; if (ncyc !== 4) $display("FAIL jnz_lat%0d: got %0d want 4", k, ncyc); else n_pass++;
            n_total++; if (dut.r_flag !== exp_flag[k]) $display("FAIL jnz_flag%0d: got %b want %b", k, dut.r_flag, exp_flag[k]); else n_pass++;
            n_total++; if (bus.imem_addr !== exp_pc[k]) $display("FAIL jnz_pc%0d: got %h want %h", k, bus.imem_addr, exp_pc[k]); else n_pass++;
        end
    endtask

    task automatic test_jmpr_wrap();
        fill_rom();
        rom[8'h00] = enc(OP_LI, 2'd1, 2'd0, 8'hF0);
        rom[8'h01] = enc(OP_JMPR, 2'd0, 2'd1, 8'h20);
        rom[8'h10] = enc(OP_JMP, 2'd0, 2'd0, 8'hFF);
        rom[8'hFF] = enc(OP_ADD, 2'd0, 2'd0, 8'h00);
        do_reset();
        run_one();
        run_one();
        n_total++; if (bus.imem_addr !== 8'h10) $display("FAIL jmpr_pc: got %h want 10", bus.imem_addr); else n_pass++;
        run_one();
        n_total++; if (bus.imem_addr !== 8'hFF) $display("FAIL jmp_pc: got %h want ff", bus.imem_addr); else n_pass++;
        run_one();
        n_total++; if (ncyc !== 4) $display("FAIL wrap_lat: got %0d want 4", ncyc); else n_pass++;
        n_total++; if (bus.imem_addr !== 8'h00) $display("FAIL wrap_pc: got %h want 00", bus.imem_addr); else n_pass++;
        run_one();
        n_total++; if (fetch_addr !== 8'h00) $display("FAIL wrap_fetch: got %h want 00", fetch_addr); else n_pass++;
    endtask

    task automatic test_reset_mid_store();
        fill_rom();
        rom[0] = enc(OP_LI, 2'd0, 2'd0, 8'd9);
        rom[1] = enc(OP_STORE, 2'd0, 2'd3, 8'h20);
        do_reset();
        run_one();
        @(negedge clk);
        bus.run = 1'b1;
        @(posedge clk); #1;
        bus.run = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_total++; if (bus.dmem_we !== 1'b1) $display("FAIL mid_pre_we: got %b want 1", bus.dmem_we); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if (bus.dmem_we !== 1'b0) $display("FAIL mid_we: got %b want 0", bus.dmem_we); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.imem_addr !== 8'h00) $display("FAIL mid_pc: got %h want 00", bus.imem_addr); else n_pass++;
        n_total++; if (dut.u_regfile.r_regs[0] !== 8'h00) $display("FAIL mid_r0: got %h want 00", dut.u_regfile.r_regs[0]); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (ram[8'h20] === 8'h09) $display("FAIL mid_ram: got %h want not 09", ram[8'h20]); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_illegal();
        fill_rom();
        rom[0] = enc(OP_LI, 2'd0, 2'd0, 8'd1);
        rom[1] = enc(OP_LI, 2'd1, 2'd0, 8'd2);
        rom[2] = 16'hF000;
        do_reset();
        run_one();
        run_one();
        run_one();
        n_total++; if (ncyc !== 2) $display("FAIL ill_lat: got %0d want 2", ncyc); else n_pass++;
        n_total++; if (bus.illegal !== 1'b1) $display("FAIL ill_flag: got %b want 1", bus.illegal); else n_pass++;
        n_total++; if (bus.imem_addr !== 8'h02) $display("FAIL ill_pc: got %h want 02", bus.imem_addr); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.run = k[0];
        end
        @(posedge clk); #1;
        n_total++; if (bus.busy !== 1'b0 || bus.imem_addr !== 8'h02 || bus.illegal !== 1'b1)
            $display("FAIL ill_hold: got busy=%b pc=%h illegal=%b want 0/02/1", bus.busy, bus.imem_addr, bus.illegal);
            else n_pass++;
        bus.run = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.run = 1'b0;
        rst_n   = 1'b0;
        test_reset();
        test_sub();
        test_store_load();
        test_jnz();
        test_jmpr_wrap();
        test_reset_mid_store();
        test_illegal();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
